branch_target_buffer: RTL and testbench

- Parametrised, direct-mapped branch target buffer with 2-bit saturating direction counters.
- Adds predicted control flow to the 5-stage pipeline, which currently resolves every branch in ID and pays a fetch bubble on each taken branch or jump.
- Lookup is combinational and is driven by the IF-stage PC. Updates come from ID-stage branch/jump resolution.
- Also provides whole-table invalidate and a saturating mispredict counter for performance measurement.

---
 rtl/branch_target_buffer.sv | 141 ++++++++++++++
 tb/tb_branch_target_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// ============================================================================
// Module   : branch_target_buffer
// Brief    : Direct-mapped BTB with 2-bit direction counters and mispredict stat
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_buffer #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              upd_is_jump,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              inv_all,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int         IDX_W       = $clog2(ENTRIES);
    localparam int         c_tag_w     = ADDR_W - IDX_W - 2;
    localparam logic [1:0] c_ctr_rst   = 2'b01;
    localparam logic [1:0] c_ctr_weak  = 2'b10;
    localparam logic [1:0] c_ctr_max   = 2'b11;
    localparam logic [1:0] c_ctr_min   = 2'b00;

    logic               r_valid  [ENTRIES];
    logic [c_tag_w-1:0] r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic [STAT_W-1:0]  r_stat;

    logic [IDX_W-1:0]   w_lk_idx;
    logic [c_tag_w-1:0] w_lk_tag;
    logic               w_lk_hit;
    logic [IDX_W-1:0]   w_upd_idx;
    logic [c_tag_w-1:0] w_upd_tag;
    logic               w_upd_hit;
    logic               w_upd_en;
    logic [1:0]         w_upd_ctr;
    logic [1:0]         w_ctr_next;
    logic               w_ctr_we;
    logic               w_target_we;
    logic               w_alloc;
    logic               w_unused;

    // Byte-offset bits never participate in indexing or tagging.
    assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign w_lk_idx  = lookup_pc[IDX_W+1:2];
    assign w_lk_tag  = lookup_pc[ADDR_W-1:IDX_W+2];
    assign w_upd_idx = upd_pc[IDX_W+1:2];
    assign w_upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // Lookup sees registered state only, so a same-cycle update is not bypassed.
    assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_hit    = w_lk_hit;
    assign pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    assign pred_target = w_lk_hit ? r_target[w_lk_idx] : '0;

    assign w_upd_en  = upd_valid && !inv_all;
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_ctr = r_ctr[w_upd_idx];

    always_comb begin
        w_ctr_next  = w_upd_ctr;
        w_ctr_we    = 1'b0;
        w_target_we = 1'b0;
        w_alloc     = 1'b0;
        if (w_upd_en) begin
            if (w_upd_hit) begin
                w_ctr_we = 1'b1;
                if (upd_is_jump) begin
                    w_ctr_next  = c_ctr_max;
                    w_target_we = 1'b1;
                end else if (upd_taken) begin
                    w_ctr_next  = (w_upd_ctr == c_ctr_max) ? c_ctr_max : w_upd_ctr + 2'd1;
                    w_target_we = 1'b1;
                end else begin
                    w_ctr_next  = (w_upd_ctr == c_ctr_min) ? c_ctr_min : w_upd_ctr - 2'd1;
                end
            end else if (upd_taken) begin
                // Taken miss evicts whatever alias lives at this index.
                w_alloc     = 1'b1;
                w_ctr_we    = 1'b1;
                w_target_we = 1'b1;
                w_ctr_next  = upd_is_jump ? c_ctr_max : c_ctr_weak;
            end
        end
    end

    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
            logic w_sel;
            assign w_sel = (w_upd_idx == IDX_W'(i));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid[i] <= 1'b0;
                    r_ctr[i]   <= c_ctr_rst;
                end else if (inv_all) begin
                    r_valid[i] <= 1'b0;
                end else if (w_sel) begin
                    if (w_alloc) begin
                        r_valid[i] <= 1'b1;
                        r_tag[i]   <= w_upd_tag;
                    end
                    if (w_ctr_we) begin
                        r_ctr[i] <= w_ctr_next;
                    end
                    if (w_target_we) begin
                        r_target[i] <= upd_target;
                    end
                end
            end
        end
    endgenerate

    // Counting is independent of inv_all so dropped updates still register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat <= '0;
        end else if (upd_valid && upd_mispredict && (r_stat != '1)) begin
            r_stat <= r_stat + STAT_W'(1);
        end
    end

    assign stat_mispredicts = r_stat;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
// ============================================================================
// Module   : tb_branch_target_buffer
// Brief    : Directed and randomized checks of branch_target_buffer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_target_buffer;

    localparam int ADDR_W  = 32;
    localparam int ENTRIES = 16;
    localparam int STAT_W  = 4;
    localparam int STAT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] lookup_pc = '0;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid = 1'b0;
    logic [ADDR_W-1:0] upd_pc = '0;
    logic              upd_taken = 1'b0;
    logic              upd_is_jump = 1'b0;
    logic [ADDR_W-1:0] upd_target = '0;
    logic              upd_mispredict = 1'b0;
    logic              inv_all = 1'b0;
    logic [STAT_W-1:0] stat_mispredicts;

    int checks = 0;
    int failures = 0;

    // Reference model: one slot per index, holding the full PC that allocated it.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_pc     [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int          m_stat;

    always #5 clk = ~clk;

    branch_target_buffer #(
        .ADDR_W (ADDR_W),
        .ENTRIES(ENTRIES),
        .STAT_W (STAT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .lookup_pc       (lookup_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_is_jump     (upd_is_jump),
        .upd_target      (upd_target),
        .upd_mispredict  (upd_mispredict),
        .inv_all         (inv_all),
        .stat_mispredicts(stat_mispredicts)
    );

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int s = slot_of(pc);
        return m_valid[s] && ((m_pc[s] / (4 * ENTRIES)) == (pc / (4 * ENTRIES)));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_tgt(input logic [31:0] pc);
        return m_hit(pc) ? m_target[slot_of(pc)] : 32'h0;
    endfunction

    task automatic model_edge(input bit r, input bit v, input bit t, input bit j,
                              input bit mis, input bit inv,
                              input logic [31:0] pc, input logic [31:0] tgt);
        int s = slot_of(pc);
        bit h = m_hit(pc);
        if (r) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 0;
                m_ctr[k]   = 1;
            end
            m_stat = 0;
            return;
        end
        if (v && mis) m_stat = (m_stat < STAT_MAX) ? m_stat + 1 : STAT_MAX;
        if (inv) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
            return;
        end
        if (!v) return;
        if (h) begin
            if (j) begin
                m_ctr[s] = 3;
                m_target[s] = tgt;
            end else if (t) begin
                m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                m_target[s] = tgt;
            end else begin
                m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
            end
        end else if (t) begin
            m_valid[s]  = 1;
            m_pc[s]     = pc;
            m_target[s] = tgt;
            m_ctr[s]    = j ? 3 : 2;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge(rst, upd_valid, upd_taken, upd_is_jump, upd_mispredict, inv_all,
                   upd_pc, upd_target);
        rst = 0;
        upd_valid = 0;
        upd_mispredict = 0;
        inv_all = 0;
        #1;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input bit t, input bit j,
                             input logic [31:0] tgt, input bit mis);
        upd_valid      = 1;
        upd_pc         = pc;
        upd_taken      = t;
        upd_is_jump    = j;
        upd_target     = tgt;
        upd_mispredict = mis;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        rst = 1;
        step();
        lookup_pc = 32'h40;
        #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%0b want=0", pred_hit); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%0b want=0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin failures++; $display("FAIL reset_target got=%h want=0", pred_target); end
        checks++; if (stat_mispredicts !== 4'd0) begin failures++; $display("FAIL reset_stat got=%0d want=0", stat_mispredicts); end
    endtask

    task automatic test_alloc();
        lookup_pc = 32'h40;
        drive_upd(32'h40, 1, 0, 32'h100, 0);
        #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL alloc_same_cycle_hit got=%0b want=0", pred_hit); end
        step();
        checks++; if (pred_hit !== 1'b1) begin failures++; $display("FAIL alloc_hit got=%0b want=1", pred_hit); end
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alloc_taken got=%0b want=1", pred_taken); end
        checks++; if (pred_target !== 32'h100) begin failures++; $display("FAIL alloc_target got=%h want=100", pred_target); end
    endtask

    task automatic test_counter();
        lookup_pc = 32'h40;
        drive_upd(32'h40, 0, 0, 32'h999, 0); step();
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL ctr_01_taken got=%0b want=0", pred_taken); end
        drive_upd(32'h40, 0, 0, 32'h999, 0); step();
        checks++; if (pred_hit !== 1'b1) begin failures++; $display("FAIL ctr_00_hit got=%0b want=1", pred_hit); end
        checks++; if (pred_target !== 32'h100) begin failures++; $display("FAIL ctr_nt_target got=%h want=100", pred_target); end
        drive_upd(32'h40, 0, 0, 32'h999, 0); step();
        drive_upd(32'h40, 1, 0, 32'h100, 0); step();
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL ctr_sat_low got=%0b want=0", pred_taken); end
        for (int k = 0; k < 3; k++) begin
            drive_upd(32'h40, 1, 0, 32'h100, 0); step();
        end
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL ctr_11_taken got=%0b want=1", pred_taken); end
        drive_upd(32'h40, 0, 0, 32'h999, 0); step();
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL ctr_10_taken got=%0b want=1", pred_taken); end
        drive_upd(32'h40, 0, 0, 32'h999, 0); step();
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL ctr_sat_high got=%0b want=0", pred_taken); end
    endtask

    task automatic test_alias();
        drive_upd(32'h80, 1, 0, 32'h200, 0); step();
        lookup_pc = 32'h40; #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL alias_evicted_hit got=%0b want=0", pred_hit); end
        lookup_pc = 32'h80; #1;
        checks++; if (pred_hit !== 1'b1) begin failures++; $display("FAIL alias_new_hit got=%0b want=1", pred_hit); end
        checks++; if (pred_target !== 32'h200) begin failures++; $display("FAIL alias_new_target got=%h want=200", pred_target); end
        drive_upd(32'hC0, 0, 0, 32'h400, 0); step();
        lookup_pc = 32'h80; #1;
        checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
            failures++; $display("FAIL alias_nt_keep got=%0b/%0b/%h want=1/1/200", pred_hit, pred_taken, pred_target);
        end
        lookup_pc = 32'hC0; #1;
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL alias_nt_noalloc got=%0b want=0", pred_hit); end
    endtask

    task automatic test_jump_inv();
        logic [31:0] pcs [4];
        pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h48; pcs[3] = 32'h80;
        drive_upd(32'h44, 1, 1, 32'h300, 0); step();
        lookup_pc = 32'h44; #1;
        checks++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h300) begin
            failures++; $display("FAIL jump_alloc got=%0b/%0b/%h want=1/1/300", pred_hit, pred_taken, pred_target);
        end
        drive_upd(32'h48, 1, 0, 32'h500, 0);
        inv_all = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            lookup_pc = pcs[k]; #1;
            checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL inv_hit pc=%h got=%0b want=0", pcs[k], pred_hit); end
        end
    endtask

    task automatic test_stats();
        for (int k = 0; k < 3; k++) begin
            drive_upd(32'h1000, 0, 0, 32'h0, 1); step();
        end
        checks++; if (stat_mispredicts !== 4'd3) begin failures++; $display("FAIL stat_count got=%0d want=3", stat_mispredicts); end
        upd_mispredict = 1; step();
        checks++; if (stat_mispredicts !== 4'd3) begin failures++; $display("FAIL stat_unqualified got=%0d want=3", stat_mispredicts); end
        for (int k = 0; k < 17; k++) begin
            drive_upd(32'h1000, 0, 0, 32'h0, 1); step();
        end
        checks++; if (stat_mispredicts !== 4'd15) begin failures++; $display("FAIL stat_saturate got=%0d want=15", stat_mispredicts); end
        drive_upd(32'h44, 1, 0, 32'h600, 0); step();
        rst = 1; step();
        lookup_pc = 32'h44; #1;
        checks++; if (stat_mispredicts !== 4'd0) begin failures++; $display("FAIL stat_reset got=%0d want=0", stat_mispredicts); end
        checks++; if (pred_hit !== 1'b0) begin failures++; $display("FAIL midrun_reset_hit got=%0b want=0", pred_hit); end
    endtask

    task automatic test_random();
        bit t;
        bit j;
        rst = 1; step();
        for (int n = 0; n < 400; n++) begin
            j = ($urandom_range(0, 4) == 0);
            t = j ? 1'b1 : 1'($urandom_range(0, 1));
            drive_upd(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
                      t, j, $urandom, ($urandom_range(0, 7) == 0));
            upd_valid = ($urandom_range(0, 3) != 0);
            inv_all   = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            lookup_pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            #1;
            checks++; if (pred_hit !== m_hit(lookup_pc)) begin
                failures++; $display("FAIL rand_hit n=%0d pc=%h got=%0b want=%0b", n, lookup_pc, pred_hit, m_hit(lookup_pc));
            end
            checks++; if (pred_taken !== m_taken(lookup_pc)) begin
                failures++; $display("FAIL rand_taken n=%0d pc=%h got=%0b want=%0b", n, lookup_pc, pred_taken, m_taken(lookup_pc));
            end
            checks++; if (pred_target !== m_tgt(lookup_pc)) begin
                failures++; $display("FAIL rand_target n=%0d pc=%h got=%h want=%h", n, lookup_pc, pred_target, m_tgt(lookup_pc));
            end
            checks++; if (int'(stat_mispredicts) != m_stat) begin
                failures++; $display("FAIL rand_stat n=%0d got=%0d want=%0d", n, stat_mispredicts, m_stat);
            end
            step();
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_jump_inv();
        test_stats();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
